// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the instruction fetch stage.
package fetch_pkg;

    localparam int          INSN_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8002_0000;
    localparam logic [31:0] NOP_INSN         = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [31:0]       pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc_in);
        return pc_in & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Signal bundle between fetch, instruction memory and decode.
// Defining FETCH_PERF_CNT_EN adds the three performance counter outputs.
interface fetch_if;
    import fetch_pkg::*;

    logic              stall;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              imem_rd_en;
    logic [31:0]       imem_addr;
    logic [INSN_W-1:0] imem_rdata;
    logic              imem_rvalid;
    logic [INSN_W-1:0] insn;
    logic [31:0]       pc;
    logic              enable_decode;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_dropped;
    logic [31:0]       perf_stall_cycles;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata, imem_rvalid,
        output imem_rd_en, imem_addr, insn, pc, enable_decode,
        output perf_fetched, perf_dropped, perf_stall_cycles
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata, imem_rvalid,
        input  imem_rd_en, imem_addr, insn, pc, enable_decode,
        input  perf_fetched, perf_dropped, perf_stall_cycles
    );
`else
    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata, imem_rvalid,
        output imem_rd_en, imem_addr, insn, pc, enable_decode
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata, imem_rvalid,
        input  imem_rd_en, imem_addr, insn, pc, enable_decode
    );
`endif

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with flush and occupancy count; head is read combinationally.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int             AW   = $clog2(DEPTH);
    localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != FULL);
    assign w_do_pop  = i_pop  && (r_count != '0);

    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads, queues responses in order for decode.
// Optional build macro FETCH_PERF_CNT_EN enables saturating performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic    clock,
    input  logic    reset,
    fetch_if.master bus
);

    localparam int               CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]   OCC_LIMIT  = (CNT_W+1)'(DEPTH);

    logic [31:0]        r_fetch_pc;
    logic [CNT_W-1:0]   r_inflight;
    logic [CNT_W-1:0]   r_drop;

    logic [CNT_W-1:0]   w_q_count;
    logic [CNT_W-1:0]   w_tag_count;
    logic [31:0]        w_tag_pc;
    fetch_entry_t       w_q_wdata;
    fetch_entry_t       w_head;
    logic               w_en;
    logic               w_pop_raw;
    logic               w_q_pop;
    logic               w_q_push;
    logic               w_discard;
    logic               w_issue;
    logic [CNT_W:0]     w_occ;

    assign w_en      = (w_q_count != '0);
    assign w_pop_raw = w_en && !bus.stall;
    assign w_q_pop   = w_pop_raw && !bus.redirect_valid;

    // Outstanding reads plus queued entries never exceed DEPTH, so every kept response has a slot.
    assign w_occ   = {1'b0, r_inflight} + {1'b0, w_q_count} - (CNT_W+1)'(w_pop_raw);
    assign w_issue = !reset && !bus.redirect_valid && (w_occ < OCC_LIMIT);

    // Responses with no matching tag are ignored rather than queued with a bogus PC.
    assign w_discard = bus.imem_rvalid && ((r_drop != '0) || bus.redirect_valid);
    assign w_q_push  = bus.imem_rvalid && (r_drop == '0) && !bus.redirect_valid
                       && (w_tag_count != '0);

    assign w_q_wdata.insn = bus.imem_rdata;
    assign w_q_wdata.pc   = w_tag_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(bus.imem_rvalid);
            if (bus.redirect_valid) begin
                r_fetch_pc <= align_pc(bus.redirect_pc);
                // Earlier drops are already part of inflight, so inflight alone is the new total.
                r_drop     <= r_inflight - CNT_W'(bus.imem_rvalid);
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + PC_INCR;
                if (bus.imem_rvalid && (r_drop != '0)) r_drop <= r_drop - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_tag_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_issue),
        .i_pop   (bus.imem_rvalid),
        .i_flush (1'b0),
        .i_wdata (r_fetch_pc),
        .o_rdata (w_tag_pc),
        .o_count (w_tag_count)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_insn_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_q_push),
        .i_pop   (w_q_pop),
        .i_flush (bus.redirect_valid),
        .i_wdata (w_q_wdata),
        .o_rdata (w_head),
        .o_count (w_q_count)
    );

    assign bus.imem_rd_en    = w_issue;
    assign bus.imem_addr     = reset ? RESET_PC : r_fetch_pc;
    assign bus.enable_decode = w_en;
    assign bus.insn          = w_en ? w_head.insn : NOP_INSN;
    assign bus.pc            = w_en ? w_head.pc   : RESET_PC;

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;
    logic [31:0] r_perf_stall_cycles;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_fetched      <= '0;
            r_perf_dropped      <= '0;
            r_perf_stall_cycles <= '0;
        end else begin
            if (w_q_push)            r_perf_fetched      <= sat_inc(r_perf_fetched);
            if (w_discard)           r_perf_dropped      <= sat_inc(r_perf_dropped);
            if (w_en && bus.stall)   r_perf_stall_cycles <= sat_inc(r_perf_stall_cycles);
        end
    end

    assign bus.perf_fetched      = r_perf_fetched;
    assign bus.perf_dropped      = r_perf_dropped;
    assign bus.perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order memory model with variable latency,
// program-order reference of the expected decode stream, directed and random phases.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fetch_if bus();

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h8002_0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { logic [31:0] pc; logic [31:0] insn; } exp_t;
    typedef struct { logic [31:0] addr; int due; bit live; } req_t;

    exp_t        exp_q[$];
    req_t        mq[$];
    logic [31:0] seen_pc[$];
    logic [31:0] iss_log[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_due = -1;
    int          m_fetched = 0;
    int          m_dropped = 0;
    int          m_stall = 0;
    logic [31:0] nf = 32'h8002_0000;

    logic        s_en, s_rd;
    logic [31:0] s_addr, s_pc, s_insn;
    logic        en_log [10];
    logic [31:0] pc_log [10];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;
        mq.delete();
        exp_q.delete();
        seen_pc.delete();
        iss_log.delete();
        m_fetched = 0;
        m_dropped = 0;
        m_stall = 0;
        last_due = -1;
        nf = 32'h8002_0000;
        @(negedge clock);
        #1;
        chk("rst_enable_decode", 32'(bus.enable_decode), 32'h0);
        chk("rst_imem_rd_en", 32'(bus.imem_rd_en), 32'h0);
        chk("rst_imem_addr", bus.imem_addr, 32'h8002_0000);
        chk("rst_insn", bus.insn, 32'h0);
        chk("rst_pc", bus.pc, 32'h8002_0000);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", bus.perf_fetched, 32'h0);
        chk("rst_perf_dropped", bus.perf_dropped, 32'h0);
        chk("rst_perf_stall", bus.perf_stall_cycles, 32'h0);
`endif
        cyc = 0;
    endtask

    // One clock cycle: drive inputs and memory response, then update the reference model.
    task automatic step(input logic st, input logic rv, input logic [31:0] rpc, input int lat);
        req_t r;
        logic resp;
        logic resp_live;
        @(negedge clock);
        reset = 1'b0;
        bus.stall = st;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        resp = 1'b0;
        resp_live = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            resp = 1'b1;
            resp_live = r.live;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata = memf(r.addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata = $urandom;
        end
        #1;
        s_en = bus.enable_decode;
        s_rd = bus.imem_rd_en;
        s_addr = bus.imem_addr;
        s_pc = bus.pc;
        s_insn = bus.insn;
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", bus.perf_fetched, 32'(m_fetched));
        chk("perf_dropped", bus.perf_dropped, 32'(m_dropped));
        chk("perf_stall_cycles", bus.perf_stall_cycles, 32'(m_stall));
`endif
        if (s_en && st) m_stall++;
        if (resp) begin
            if (resp_live && !rv) m_fetched++;
            else m_dropped++;
        end
        if (rv) begin
            chk("rd_en_on_redirect", 32'(s_rd), 32'h0);
            exp_q.delete();
            nf = {rpc[31:2], 2'b00};
            foreach (mq[i]) mq[i].live = 1'b0;
        end
        if (s_rd) begin
            r.addr = s_addr;
            r.due = cyc + lat;
            if (r.due <= last_due) r.due = last_due + 1;
            r.live = !rv;
            last_due = r.due;
            mq.push_back(r);
            if (!rv) begin
                chk("imem_addr", s_addr, nf);
                iss_log.push_back(s_addr);
                exp_q.push_back('{nf, memf(nf)});
                nf = nf + 32'd4;
            end
        end
        cyc++;
    endtask

    // Monitor: whatever decode sees must be the oldest not-yet-consumed fetch on the current path.
    always @(negedge clock) begin
        #2;
        if (!reset && bus.enable_decode && !bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stale_entry: got pc %h expected no valid entry", bus.pc);
            end else begin
                chk("dec_pc", bus.pc, exp_q[0].pc);
                chk("dec_insn", bus.insn, exp_q[0].insn);
                if (!bus.stall) begin
                    seen_pc.push_back(bus.pc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;

        // L=1 streaming from reset
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, 32'h0, 1);
            en_log[c] = s_en;
            pc_log[c] = s_pc;
        end
        chk("l1_en_c0", 32'(en_log[0]), 32'h0);
        chk("l1_en_c1", 32'(en_log[1]), 32'h0);
        for (int c = 2; c < 10; c++) chk("l1_en_sustained", 32'(en_log[c]), 32'h1);
        chk("l1_pc_c2", pc_log[2], 32'h8002_0000);
        chk("l1_pc_c3", pc_log[3], 32'h8002_0004);
        chk("l1_pc_c4", pc_log[4], 32'h8002_0008);

        // Stall held with a full queue
        do_reset();
        for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 32'h0, 1);
        chk("stall_rd_en", 32'(s_rd), 32'h0);
        chk("stall_outstanding", 32'(exp_q.size()), 32'(DEPTH));
        chk("stall_head_pc", s_pc, 32'h8002_0000);
        seen_pc.delete();
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b0, 32'h0, 1);
            chk("release_en", 32'(s_en), 32'h1);
        end
        #3;
        chk("release_pops", 32'(seen_pc.size()), 32'h4);
        for (int i = 0; i < 4 && i < seen_pc.size(); i++)
            chk("release_pc", seen_pc[i], 32'h8002_0000 + 32'(4 * i));

        // L=3 redirect with three reads in flight
        do_reset();
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 32'h0, 3);
        chk("pre_redirect_inflight", 32'(mq.size()), 32'h3);
        step(1'b0, 1'b1, 32'h8002_0103, 3);
        seen_pc.delete();
        for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 32'h0, 3);
        #3;
        if (seen_pc.size() >= 2) begin
            chk("redir_first_pc", seen_pc[0], 32'h8002_0100);
            chk("redir_second_pc", seen_pc[1], 32'h8002_0104);
        end else begin
            chk("redir_pops", 32'(seen_pc.size()), 32'h2);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("redir_perf_dropped", bus.perf_dropped, 32'h3);
`endif

        // Redirect coinciding with a response and a pop
        do_reset();
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 32'h0, 1);
        step(1'b0, 1'b1, 32'h9000_0040, 1);
        chk("coinc_en_at_redirect", 32'(s_en), 32'h1);
        chk("coinc_rvalid_at_redirect", 32'(bus.imem_rvalid), 32'h1);
        seen_pc.delete();
        step(1'b0, 1'b0, 32'h0, 1);
        chk("coinc_en_next", 32'(s_en), 32'h0);
        chk("coinc_issue_next", 32'(s_rd), 32'h1);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 32'h0, 1);
        #3;
        if (seen_pc.size() >= 1) chk("coinc_first_pc", seen_pc[0], 32'h9000_0040);
        else chk("coinc_pops", 32'(seen_pc.size()), 32'h1);

        // PC wrap at the top of the address space
        do_reset();
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1);
        iss_log.delete();
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 32'h0, 1);
        if (iss_log.size() >= 2) begin
            chk("wrap_addr0", iss_log[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", iss_log[1], 32'h0000_0000);
        end else begin
            chk("wrap_issues", 32'(iss_log.size()), 32'h2);
        end

        // Random traffic
        do_reset();
        seen_pc.delete();
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 3)  ? 1'b1 : 1'b0,
                 $urandom,
                 int'($urandom_range(1, 4)));
        end
        #3;
        chk("random_progress", 32'(seen_pc.size() >= 500), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
